// File: rtl/mmu_pkg.sv
// Shared encodings for the tasked 6809 MMU: register offsets, device codes, map entry layout.
// Pure declarations; no timing or flow-control content.
package mmu_pkg;
   localparam logic [7:0] OFS_CTRL  = 8'h10;
   localparam logic [7:0] OFS_AKEY  = 8'h11;
   localparam logic [7:0] OFS_TKEY  = 8'h12;
   localparam logic [7:0] OFS_RTI   = 8'h13;
   localparam logic [7:0] OFS_FSTAT = 8'h14;
   localparam logic [7:0] OFS_WIN   = 8'h20;
   localparam logic [7:0] OFS_EXT   = 8'h30;

   localparam logic [7:0] RTI_OPCODE = 8'h3B;

   typedef enum logic [1:0] {
      DEV_ROM0 = 2'b00,
      DEV_ROM1 = 2'b01,
      DEV_RAM  = 2'b10,
      DEV_EXT  = 2'b11
   } dev_e;

   // Map entry: [7:6] device, [5] write protect, [4:0] physical page
   localparam int ENT_DEV_LSB = 6;
   localparam int ENT_WP_BIT  = 5;
   localparam int ENT_PPAGE_W = 5;

   typedef struct packed {
      dev_e                   dev;
      logic                   wp;
      logic [ENT_PPAGE_W-1:0] ppage;
   } entry_t;

   // {QX,EX} encodings of the bus clock phases
   typedef enum logic [1:0] {
      CK_IDLE = 2'b00,
      CK_Q    = 2'b10,
      CK_QE   = 2'b11,
      CK_E    = 2'b01
   } ck_state_e;
endpackage

// File: rtl/mmu_clkgen.sv
// Q/E generator for the 6809 from CLKX4; cycle_end marks the commit edge of each bus cycle.
// Fixed 4 CLKX4 per bus cycle; MRDY low holds the E-high-Q-low phase indefinitely.
module mmu_clkgen
   import mmu_pkg::*;
(
   input  logic CLKX4,
   input  logic RESET,
   input  logic MRDY,
   output logic QX,
   output logic EX,
   output logic cycle_end
);

   ck_state_e state, state_nxt;

   always_ff @(posedge CLKX4) begin
      if (RESET) state <= CK_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      cycle_end = 1'b0;
      case (state)
         CK_IDLE: state_nxt = CK_Q;
         CK_Q:    state_nxt = CK_QE;
         CK_QE:   state_nxt = CK_E;
         CK_E: begin
            if (MRDY) begin
               state_nxt = CK_IDLE;
               cycle_end = 1'b1;
            end
         end
      endcase
   end

   assign QX = state[1];
   assign EX = state[0];

endmodule

// File: rtl/mmu_tasked.sv
// Tasked 6809 MMU: page translation, chip selects, write protect with sticky fault counter.
// Combinational translation (zero latency); all state commits at cycle_end, stretched by MRDY.
module mmu_tasked
   import mmu_pkg::*;
#(
   parameter logic [15:0] IO_PAGE   = 16'hFE00,
   parameter int          TASK_BITS = 5,
   parameter int          PAGE_BITS = 3
) (
   input  logic       CLKX4,
   input  logic       RESET,
   input  logic [15:0] ADDR,
   input  logic       RnW,
   input  logic       BA,
   input  logic       BS,
   input  logic       MRDY,
   input  logic [7:0] DATA_IN,
   output logic [7:0] DATA_OUT,
   output logic       DATA_OE,
   output logic       QX,
   output logic       EX,
   output logic [4:0] PPAGE,
   output logic       nRD,
   output logic       nWR,
   output logic       nCSROM0,
   output logic       nCSROM1,
   output logic       nCSRAM,
   output logic       nCSUART,
   output logic       nCSEXT,
   output logic       nBUFEN,
   output logic       BUFDIR,
   output logic       A11X,
   output logic       FAULT
);

   localparam int         MAP_AW  = TASK_BITS + PAGE_BITS;
   localparam logic [8:0] WIN_END = 9'(OFS_WIN) + 9'(1 << PAGE_BITS);

   logic                 cycle_end;
   logic                 enmmu, wpen, s_mode, fault;
   logic [6:0]           fcount;
   logic [TASK_BITS-1:0] access_key, task_key, xl_task;
   logic [7:0]           map_ram [0:(1<<MAP_AW)-1];

   logic [7:0]           ofs;
   logic [PAGE_BITS-1:0] lpage;
   logic [MAP_AW-1:0]    win_addr;
   logic                 io, vector, reg_hit, win_hit, ext_sel, prot, mem_sel;
   entry_t               xl_ent;
   dev_e                 dev;

   mmu_clkgen u_clkgen (
      .CLKX4     (CLKX4),
      .RESET     (RESET),
      .MRDY      (MRDY),
      .QX        (QX),
      .EX        (EX),
      .cycle_end (cycle_end)
   );

   assign ofs      = ADDR[7:0];
   assign lpage    = ADDR[15 -: PAGE_BITS];
   assign io       = (ADDR[15:8] == IO_PAGE[15:8]);
   assign vector   = !BA && BS && RnW;
   assign reg_hit  = io && (ofs >= OFS_CTRL) && (ofs <= OFS_FSTAT);
   assign win_hit  = io && (ofs >= OFS_WIN) && ({1'b0, ofs} < WIN_END);
   assign win_addr = {access_key, ofs[PAGE_BITS-1:0]};

   // Vector fetches and supervisor mode always run under task 0
   assign xl_task = (vector || s_mode) ? '0 : task_key;
   assign xl_ent  = map_ram[{xl_task, lpage}];

   always_comb begin
      dev   = ADDR[15] ? DEV_ROM0 : DEV_RAM;
      PPAGE = 5'(lpage);
      if (enmmu) begin
         dev   = xl_ent.dev;
         PPAGE = xl_ent.ppage;
      end
   end

   assign mem_sel = EX && !io;
   assign nCSROM0 = !(mem_sel && dev == DEV_ROM0);
   assign nCSROM1 = !(mem_sel && dev == DEV_ROM1);
   assign nCSRAM  = !(mem_sel && dev == DEV_RAM);
   assign nCSUART = !(EX && io && ofs[7:4] == 4'h0);
   assign ext_sel = EX && enmmu && (io ? (ofs >= OFS_EXT) : (dev == DEV_EXT));
   assign nCSEXT  = !(BA ^ ext_sel);
   assign nBUFEN  = !(BA ^ ext_sel);
   assign BUFDIR  = BA ^ RnW;
   assign A11X    = ADDR[11] ^ vector;

   assign prot    = enmmu && wpen && xl_ent.wp && !RnW && !io;
   assign nRD     = !(EX && RnW);
   assign nWR     = !(EX && !RnW && !prot);
   assign DATA_OE = EX && RnW && (reg_hit || win_hit);
   assign FAULT   = fault;

   always_comb begin
      DATA_OUT = 8'h00;
      if (win_hit) begin
         DATA_OUT = map_ram[win_addr];
      end else if (io) begin
         case (ofs)
            OFS_CTRL:  DATA_OUT = {5'b0, s_mode, wpen, enmmu};
            OFS_AKEY:  DATA_OUT = 8'(access_key);
            OFS_TKEY:  DATA_OUT = 8'(task_key);
            OFS_RTI:   DATA_OUT = RTI_OPCODE;
            OFS_FSTAT: DATA_OUT = {fault, fcount};
            default:   DATA_OUT = 8'h00;
         endcase
      end
   end

   always_ff @(posedge CLKX4) begin
      if (RESET) begin
         enmmu      <= 1'b0;
         wpen       <= 1'b0;
         s_mode     <= 1'b1;
         access_key <= '0;
         task_key   <= '0;
         fault      <= 1'b0;
         fcount     <= 7'd0;
      end else if (cycle_end) begin
         if (!RnW && io) begin
            case (ofs)
               OFS_CTRL:  {wpen, enmmu} <= DATA_IN[1:0];
               OFS_AKEY:  access_key <= DATA_IN[TASK_BITS-1:0];
               OFS_TKEY:  task_key <= DATA_IN[TASK_BITS-1:0];
               OFS_FSTAT: begin
                  fault  <= 1'b0;
                  fcount <= 7'd0;
               end
               default: ;
            endcase
         end
         if (vector)                           s_mode <= 1'b1;
         else if (RnW && io && ofs == OFS_RTI) s_mode <= 1'b0;
         if (prot) begin
            fault <= 1'b1;
            if (fcount != 7'h7F) fcount <= fcount + 7'd1;
         end
      end
   end

   // Map contents survive reset; only the write is suppressed by it
   always_ff @(posedge CLKX4) begin
      if (!RESET && cycle_end && !RnW && win_hit)
         map_ram[win_addr] <= DATA_IN;
   end

endmodule

// File: tb/tb_mmu_tasked.sv
// Directed bench for mmu_tasked: clock phases, translation, write protect, vectors, reset abort.
module tb_mmu_tasked;
   logic        CLKX4 = 1'b0;
   logic        RESET = 1'b1;
   logic [15:0] ADDR = 16'h0000;
   logic        RnW = 1'b1, BA = 1'b0, BS = 1'b0, MRDY = 1'b1;
   logic [7:0]  DATA_IN = 8'h00;
   logic [7:0]  DATA_OUT;
   logic        DATA_OE, QX, EX, nRD, nWR, nCSROM0, nCSROM1, nCSRAM, nCSUART;
   logic        nCSEXT, nBUFEN, BUFDIR, A11X, FAULT;
   logic [4:0]  PPAGE;

   int total = 0;
   int bad = 0;

   logic [7:0] s_dout;
   logic [4:0] s_ppage;
   logic       s_oe, s_nwr, s_rom0, s_ram, s_uart, s_ext, s_a11x;

   always #5 CLKX4 = ~CLKX4;

   mmu_tasked dut (
      .CLKX4(CLKX4), .RESET(RESET), .ADDR(ADDR), .RnW(RnW), .BA(BA), .BS(BS),
      .MRDY(MRDY), .DATA_IN(DATA_IN), .DATA_OUT(DATA_OUT), .DATA_OE(DATA_OE),
      .QX(QX), .EX(EX), .PPAGE(PPAGE), .nRD(nRD), .nWR(nWR), .nCSROM0(nCSROM0),
      .nCSROM1(nCSROM1), .nCSRAM(nCSRAM), .nCSUART(nCSUART), .nCSEXT(nCSEXT),
      .nBUFEN(nBUFEN), .BUFDIR(BUFDIR), .A11X(A11X), .FAULT(FAULT)
   );

   // One full bus cycle starting from phase 00; outputs captured in phase 01
   task automatic bus(input logic [15:0] a, input logic rnw, input logic [7:0] wd,
                      input logic bs);
      ADDR = a; RnW = rnw; DATA_IN = wd; BS = bs; MRDY = 1'b1;
      repeat (3) @(posedge CLKX4);
      #1;
      s_dout = DATA_OUT; s_oe = DATA_OE; s_nwr = nWR; s_rom0 = nCSROM0;
      s_ram = nCSRAM; s_uart = nCSUART; s_ext = nCSEXT; s_a11x = A11X; s_ppage = PPAGE;
      @(posedge CLKX4);
      #1;
      RnW = 1'b1; BS = 1'b0;
   endtask

   task automatic test_reset;
      RESET = 1'b1;
      repeat (3) @(posedge CLKX4);
      #1;
      total++; if ({QX, EX} !== 2'b00) begin bad++; $display("FAIL rst_qe got=%b exp=00", {QX, EX}); end
      total++; if ({nRD, nWR, nCSRAM, nCSROM0, nCSUART} !== 5'b11111) begin bad++; $display("FAIL rst_strobes got=%b exp=11111", {nRD, nWR, nCSRAM, nCSROM0, nCSUART}); end
      total++; if (nCSEXT !== 1'b1) begin bad++; $display("FAIL rst_csext got=%b exp=1", nCSEXT); end
      RESET = 1'b0;
      bus(16'hFE10, 1'b1, 8'h00, 1'b0);
      total++; if (s_dout !== 8'h04) begin bad++; $display("FAIL rst_ctrl got=%h exp=04", s_dout); end
      total++; if (s_oe !== 1'b1) begin bad++; $display("FAIL rst_oe got=%b exp=1", s_oe); end
      bus(16'hFE14, 1'b1, 8'h00, 1'b0);
      total++; if (s_dout !== 8'h00 || FAULT !== 1'b0) begin bad++; $display("FAIL rst_fstat got=%h/%b exp=00/0", s_dout, FAULT); end
      bus(16'h8000, 1'b1, 8'h00, 1'b0);
      total++; if ({s_rom0, s_ram, s_ppage} !== {1'b0, 1'b1, 5'd4}) begin bad++; $display("FAIL nommu_rom got=%b%b/%h exp=01/04", s_rom0, s_ram, s_ppage); end
      bus(16'h2000, 1'b1, 8'h00, 1'b0);
      total++; if ({s_rom0, s_ram, s_ppage} !== {1'b1, 1'b0, 5'd1}) begin bad++; $display("FAIL nommu_ram got=%b%b/%h exp=10/01", s_rom0, s_ram, s_ppage); end
      bus(16'hFE30, 1'b1, 8'h00, 1'b0);
      total++; if (s_ext !== 1'b1) begin bad++; $display("FAIL nommu_ext got=%b exp=1", s_ext); end
   endtask

   task automatic test_clkgen;
      logic [1:0] seq [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
      ADDR = 16'h0000; RnW = 1'b1; MRDY = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge CLKX4); #1;
         total++; if ({QX, EX} !== seq[i % 4]) begin bad++; $display("FAIL clk_seq%0d got=%b exp=%b", i, {QX, EX}, seq[i % 4]); end
      end
      @(posedge CLKX4); @(posedge CLKX4);
      #1; MRDY = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge CLKX4); #1;
         total++; if ({QX, EX} !== 2'b01) begin bad++; $display("FAIL clk_stretch%0d got=%b exp=01", i, {QX, EX}); end
      end
      MRDY = 1'b1;
      @(posedge CLKX4); #1;
      total++; if ({QX, EX} !== 2'b00) begin bad++; $display("FAIL clk_release got=%b exp=00", {QX, EX}); end
   endtask

   task automatic test_map;
      bus(16'hFE11, 1'b0, 8'h03, 1'b0);
      bus(16'hFE22, 1'b0, 8'h87, 1'b0);
      bus(16'hFE12, 1'b0, 8'h03, 1'b0);
      bus(16'hFE10, 1'b0, 8'h01, 1'b0);
      bus(16'hFE13, 1'b1, 8'h00, 1'b0);
      total++; if ({s_dout, s_oe} !== {8'h3B, 1'b1}) begin bad++; $display("FAIL rti_read got=%h/%b exp=3b/1", s_dout, s_oe); end
      bus(16'hFE10, 1'b1, 8'h00, 1'b0);
      total++; if (s_dout !== 8'h01) begin bad++; $display("FAIL ctrl_s_clr got=%h exp=01", s_dout); end
      bus(16'hFE22, 1'b1, 8'h00, 1'b0);
      total++; if (s_dout !== 8'h87) begin bad++; $display("FAIL win_read got=%h exp=87", s_dout); end
      bus(16'h4123, 1'b1, 8'h00, 1'b0);
      total++; if ({s_ram, s_rom0, s_ppage} !== {1'b0, 1'b1, 5'd7}) begin bad++; $display("FAIL xlate_ram got=%b%b/%h exp=01/07", s_ram, s_rom0, s_ppage); end
      bus(16'hFE05, 1'b1, 8'h00, 1'b0);
      total++; if ({s_uart, s_ram, s_oe} !== 3'b010) begin bad++; $display("FAIL uart_sel got=%b exp=010", {s_uart, s_ram, s_oe}); end
      bus(16'hFE30, 1'b1, 8'h00, 1'b0);
      total++; if (s_ext !== 1'b0) begin bad++; $display("FAIL io_ext got=%b exp=0", s_ext); end
   endtask

   task automatic test_write_protect;
      bus(16'hFE22, 1'b0, 8'hA7, 1'b0);
      bus(16'hFE10, 1'b0, 8'h03, 1'b0);
      bus(16'h4000, 1'b0, 8'h55, 1'b0);
      total++; if ({s_nwr, s_ram} !== 2'b10) begin bad++; $display("FAIL wp_nwr got=%b exp=10", {s_nwr, s_ram}); end
      bus(16'hFE14, 1'b1, 8'h00, 1'b0);
      total++; if (s_dout !== 8'h81 || FAULT !== 1'b1) begin bad++; $display("FAIL wp_fstat got=%h/%b exp=81/1", s_dout, FAULT); end
      bus(16'hFE14, 1'b0, 8'h00, 1'b0);
      total++; if (s_nwr !== 1'b0) begin bad++; $display("FAIL io_nwr got=%b exp=0", s_nwr); end
      bus(16'hFE14, 1'b1, 8'h00, 1'b0);
      total++; if (s_dout !== 8'h00 || FAULT !== 1'b0) begin bad++; $display("FAIL fstat_clr got=%h/%b exp=00/0", s_dout, FAULT); end
   endtask

   task automatic test_fault_saturate;
      for (int i = 0; i < 126; i++) bus(16'h4000, 1'b0, 8'h55, 1'b0);
      bus(16'hFE14, 1'b1, 8'h00, 1'b0);
      total++; if (s_dout !== 8'hFE) begin bad++; $display("FAIL cnt126 got=%h exp=fe", s_dout); end
      for (int i = 0; i < 4; i++) bus(16'h4000, 1'b0, 8'h55, 1'b0);
      bus(16'hFE14, 1'b1, 8'h00, 1'b0);
      total++; if (s_dout !== 8'hFF) begin bad++; $display("FAIL cnt_sat got=%h exp=ff", s_dout); end
   endtask

   task automatic test_vector;
      bus(16'hFE11, 1'b0, 8'h03, 1'b0);
      bus(16'hFE27, 1'b0, 8'h8A, 1'b0);
      bus(16'hFE11, 1'b0, 8'h00, 1'b0);
      bus(16'hFE27, 1'b0, 8'h1F, 1'b0);
      bus(16'hFFFE, 1'b1, 8'h00, 1'b0);
      total++; if ({s_ram, s_ppage, s_a11x} !== {1'b0, 5'h0A, 1'b1}) begin bad++; $display("FAIL user_task got=%b/%h/%b exp=0/0a/1", s_ram, s_ppage, s_a11x); end
      bus(16'hFFFE, 1'b1, 8'h00, 1'b1);
      total++; if ({s_rom0, s_ram, s_ppage, s_a11x} !== {1'b0, 1'b1, 5'h1F, 1'b0}) begin bad++; $display("FAIL vec_task0 got=%b%b/%h/%b exp=01/1f/0", s_rom0, s_ram, s_ppage, s_a11x); end
      bus(16'hFE10, 1'b1, 8'h00, 1'b0);
      total++; if (s_dout !== 8'h07) begin bad++; $display("FAIL vec_s_set got=%h exp=07", s_dout); end
      bus(16'hFFFE, 1'b1, 8'h00, 1'b0);
      total++; if (s_ppage !== 5'h1F) begin bad++; $display("FAIL super_task got=%h exp=1f", s_ppage); end
   endtask

   task automatic test_reset_abort;
      ADDR = 16'hFE10; RnW = 1'b0; DATA_IN = 8'h01; MRDY = 1'b1;
      @(posedge CLKX4); @(posedge CLKX4); #1;
      total++; if (EX !== 1'b1) begin bad++; $display("FAIL abort_ehigh got=%b exp=1", EX); end
      RESET = 1'b1;
      @(posedge CLKX4); #1;
      total++; if ({QX, EX} !== 2'b00) begin bad++; $display("FAIL abort_qe got=%b exp=00", {QX, EX}); end
      RESET = 1'b0; RnW = 1'b1;
      bus(16'hFE10, 1'b1, 8'h00, 1'b0);
      total++; if (s_dout !== 8'h04) begin bad++; $display("FAIL abort_ctrl got=%h exp=04", s_dout); end
      bus(16'hFE14, 1'b1, 8'h00, 1'b0);
      total++; if (s_dout !== 8'h00) begin bad++; $display("FAIL abort_fstat got=%h exp=00", s_dout); end
   endtask

   initial begin
      test_reset;
      test_clkgen;
      test_map;
      test_write_protect;
      test_fault_saturate;
      test_vector;
      test_reset_abort;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

endmodule
